// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the spiking-classifier output path.
package snn_pkg;

    // Default geometry of the output layer and its presentation window.
    localparam int N_OUT  = 10;
    localparam int WINDOW = 672;   // two 336-cycle half-windows
    localparam int CNT_W  = 10;
    localparam int ID_W   = 4;

    // Class id reported when no neuron fired during the window.
    localparam int CLASS_NONE = 0;

    // Decoder FSM encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_COUNT = 2'd1;
    localparam state_t ST_SCAN  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

endpackage

// File: rtl/spike_count_bank.sv
// Bank of saturating per-neuron spike counters with a shared clear,
// a common count enable and one combinational indexed read port.
module spike_count_bank #(
    parameter int N_OUT = 10,
    parameter int CNT_W = 10,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [N_OUT-1:0] spike,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);

    logic [CNT_W-1:0] cnt [N_OUT];

    // Accumulate spikes per neuron, holding at the maximum count.
    // NOTE: counters are reset explicitly; a stale count would otherwise leak into the first result after reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
        end else if (en) begin
            // NOTE: sequential state uses <= so every counter samples the same pre-edge values.
            for (int i = 0; i < N_OUT; i++) begin
                if (spike[i] && (cnt[i] != {CNT_W{1'b1}})) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // Indexed read used by the sequential argmax; out-of-range reads return 0.
    always_comb begin
        // NOTE: default first so the mux never infers a latch for unmatched indices.
        rd_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = cnt[i];
        end
    end

endmodule

// File: rtl/spike_class_decoder.sv
// Counts output-neuron spikes over one presentation window, then scans the
// counters one per cycle to find the winning class (1..N_OUT, 0 = silent)
// and presents it on a valid/ready result port.
module spike_class_decoder
    import snn_pkg::*;
#(
    parameter int N_OUT  = snn_pkg::N_OUT,
    parameter int WINDOW = snn_pkg::WINDOW,
    parameter int CNT_W  = snn_pkg::CNT_W,
    parameter int ID_W   = snn_pkg::ID_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_OUT-1:0] spike,
    input  logic             learn,
    input  logic             start,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ID_W-1:0]  res_class,
    output logic [CNT_W-1:0] res_count,
    output logic             res_tie,
    output logic             res_learn
);

    localparam int WCNT_W = $clog2(WINDOW);

    // Class ids 1..N_OUT plus the "none" code must fit in ID_W bits.
    if (N_OUT > (2 ** ID_W) - 1) begin : g_id_width_check
        $error("spike_class_decoder: N_OUT does not fit in ID_W bits");
    end

    state_t            state;
    logic [WCNT_W-1:0] wcnt;
    logic              learn_q;
    logic [ID_W-1:0]   scan_idx;
    logic [CNT_W-1:0]  best_cnt;
    logic [ID_W-1:0]   best_cls;
    logic              best_tie;

    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  nb_cnt;
    logic [ID_W-1:0]   nb_cls;
    logic              nb_tie;
    logic              start_acc;
    logic              bank_clear;
    logic              bank_en;

    // A start is honoured in IDLE, COUNT, and in HOLD only alongside the handshake.
    assign start_acc  = start && ((state == ST_IDLE) || (state == ST_COUNT) ||
                                  ((state == ST_HOLD) && res_ready));
    assign bank_clear = (state == ST_IDLE) || start_acc;
    assign bank_en    = (state == ST_COUNT) && !start;
    assign busy       = (state == ST_COUNT) || (state == ST_SCAN);

    spike_count_bank #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W),
        .IDX_W (ID_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .clear   (bank_clear),
        .en      (bank_en),
        .spike   (spike),
        .rd_idx  (scan_idx),
        .rd_data (rd_cnt)
    );

    // One argmax step: strictly greater replaces the best, so the lowest index wins ties.
    always_comb begin
        nb_cnt = best_cnt;
        nb_cls = best_cls;
        nb_tie = best_tie;
        if (rd_cnt > best_cnt) begin
            nb_cnt = rd_cnt;
            nb_cls = scan_idx + ID_W'(1);
            nb_tie = 1'b0;
        end else if ((rd_cnt == best_cnt) && (best_cnt != '0)) begin
            nb_tie = 1'b1;
        end
    end

    // Window sequencing, argmax scan and registered result port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wcnt      <= '0;
            learn_q   <= 1'b0;
            scan_idx  <= '0;
            best_cnt  <= '0;
            best_cls  <= ID_W'(CLASS_NONE);
            best_tie  <= 1'b0;
            res_valid <= 1'b0;
            res_class <= ID_W'(CLASS_NONE);
            res_count <= '0;
            res_tie   <= 1'b0;
            res_learn <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wcnt    <= '0;
                    learn_q <= 1'b0;
                    if (start) state <= ST_COUNT;
                end
                ST_COUNT: begin
                    if (start) begin
                        wcnt    <= '0;
                        learn_q <= 1'b0;
                    end else begin
                        learn_q <= learn_q | learn;
                        if (wcnt == WCNT_W'(WINDOW - 1)) begin
                            state    <= ST_SCAN;
                            scan_idx <= '0;
                            best_cnt <= '0;
                            best_cls <= ID_W'(CLASS_NONE);
                            best_tie <= 1'b0;
                        end else begin
                            wcnt <= wcnt + WCNT_W'(1);
                        end
                    end
                end
                ST_SCAN: begin
                    best_cnt <= nb_cnt;
                    best_cls <= nb_cls;
                    best_tie <= nb_tie;
                    if (scan_idx == ID_W'(N_OUT - 1)) begin
                        state     <= ST_HOLD;
                        res_valid <= 1'b1;
                        res_class <= nb_cls;
                        res_count <= nb_cnt;
                        res_tie   <= nb_tie;
                        res_learn <= learn_q;
                    end else begin
                        scan_idx <= scan_idx + ID_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            state   <= ST_COUNT;
                            wcnt    <= '0;
                            learn_q <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_class_decoder.sv
// Scoreboard bench for spike_class_decoder: two instances (CNT_W 10 and 8)
// share stimulus; expected results are queued at start and popped on handshake.
module tb_spike_class_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       learn;
    logic       res_ready;
    logic [9:0] spike;

    logic       busy_a, valid_a, tie_a, learn_a;
    logic [3:0] class_a;
    logic [9:0] count_a;
    logic       busy_b, valid_b, tie_b, learn_b;
    logic [3:0] class_b;
    logic [7:0] count_b;

    spike_class_decoder u_dut_a (
        .clk(clk), .rst(rst), .spike(spike), .learn(learn), .start(start),
        .busy(busy_a), .res_valid(valid_a), .res_ready(res_ready),
        .res_class(class_a), .res_count(count_a), .res_tie(tie_a), .res_learn(learn_a)
    );

    spike_class_decoder #(.CNT_W(8)) u_dut_b (
        .clk(clk), .rst(rst), .spike(spike), .learn(learn), .start(start),
        .busy(busy_b), .res_valid(valid_b), .res_ready(res_ready),
        .res_class(class_b), .res_count(count_b), .res_tie(tie_b), .res_learn(learn_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cls;
        int cnt;
        int tie;
        int lrn;
        int rise;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   errors = 0;
    int   checks = 0;
    int   hs_a   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] pat(input int t, input int k);
        logic [9:0] p;
        p = '0;
        case (t)
            1: p[3] = (k % 4 == 0);
            2: if ((k % 2 == 1) && (k < 100)) begin p[2] = 1'b1; p[7] = 1'b1; end
            4: p[0] = 1'b1;
            5: p[1] = 1'b1;
            6: p[6] = (k % 8 == 0);
            7: if ((k == 10) || (k == 200) || (k == 600)) begin p[8] = 1'b1; p[4] = 1'b1; end
            8: p[0] = 1'b1;
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic lrn(input int t, input int k);
        return ((t == 4) && (k == 300)) || ((t == 5) && (k == 100));
    endfunction

    task automatic push(input int cls, input int cnt, input int tie, input int l, input int rise);
        exp_t e;
        e.cls = cls; e.cnt = cnt; e.tie = tie; e.lrn = l; e.rise = rise;
        q_a.push_back(e);
        e.cnt = (cnt > 255) ? 255 : cnt;
        q_b.push_back(e);
    endtask

    // Called #1 after an edge; start is sampled at the next edge.
    task automatic do_start(input logic [9:0] sp, output int s);
        start = 1'b1;
        spike = sp;
        s     = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        spike = '0;
    endtask

    task automatic run_count(input int t, input int n);
        for (int k = 0; k < n; k++) begin
            spike = pat(t, k);
            learn = lrn(t, k);
            @(posedge clk); #1;
        end
        spike = '0;
        learn = 1'b0;
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while ((hs_a < target) && (n < 100)) begin
            @(posedge clk); #1;
            n++;
        end
        check("handshake_seen", hs_a >= target, 1);
    endtask

    // Monitor for the CNT_W=10 instance.
    logic prev_a = 1'b0;
    int   rise_a = 0;
    exp_t e_a;
    always @(negedge clk) begin
        if (valid_a && !prev_a) rise_a = cyc;
        prev_a = valid_a;
        if (valid_a && res_ready) begin
            if (q_a.size() == 0) begin
                check("unexpected_result_a", 1, 0);
            end else begin
                e_a = q_a.pop_front();
                check("class_a",   class_a, e_a.cls);
                check("count_a",   count_a, e_a.cnt);
                check("tie_a",     tie_a,   e_a.tie);
                check("learn_a",   learn_a, e_a.lrn);
                check("latency_a", rise_a,  e_a.rise);
            end
            hs_a++;
        end
    end

    // Monitor for the CNT_W=8 instance.
    logic prev_b = 1'b0;
    int   rise_b = 0;
    exp_t e_b;
    always @(negedge clk) begin
        if (valid_b && !prev_b) rise_b = cyc;
        prev_b = valid_b;
        if (valid_b && res_ready) begin
            if (q_b.size() == 0) begin
                check("unexpected_result_b", 1, 0);
            end else begin
                e_b = q_b.pop_front();
                check("class_b",   class_b, e_b.cls);
                check("count_b",   count_b, e_b.cnt);
                check("tie_b",     tie_b,   e_b.tie);
                check("learn_b",   learn_b, e_b.lrn);
                check("latency_b", rise_b,  e_b.rise);
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_busy_a"},  busy_a,  0);
        check({tag, "_class_a"}, class_a, 0);
        check({tag, "_count_a"}, count_a, 0);
        check({tag, "_tie_a"},   tie_a,   0);
        check({tag, "_learn_a"}, learn_a, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_count_b"}, count_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        rst = 1'b1; start = 1'b0; learn = 1'b0; spike = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single neuron 3, every 4th cycle.
        do_start('0, s); push(4, 168, 0, 0, s + 683); run_count(1, 672); wait_hs(1);
        // Neurons 2 and 7 tie at 50; lowest index wins.
        do_start('0, s); push(3, 50, 1, 0, s + 683); run_count(2, 672); wait_hs(2);
        // Silent window.
        do_start('0, s); push(0, 0, 0, 0, s + 683); run_count(3, 672); wait_hs(3);
        // Neuron 0 every cycle (saturates on the 8-bit instance), one learn pulse.
        do_start('0, s); push(1, 672, 0, 1, s + 683); run_count(4, 672); wait_hs(4);

        // Restart after 300 cycles; earlier spikes and learn must be discarded,
        // spikes in the restart cycle itself are not counted.
        do_start('0, s);
        run_count(5, 299);
        do_start(10'b10_0000_0010, s);
        push(7, 84, 0, 0, s + 683);
        run_count(6, 672);
        start = 1'b1;                       // in SCAN: ignored
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b0;
        wait_hs(5);

        // Back-pressure: result held while res_ready is low, start ignored.
        res_ready = 1'b0;
        do_start('0, s); push(5, 3, 1, 0, s + 683); run_count(7, 672);
        n = 0;
        while (!valid_a && (n < 50)) begin @(posedge clk); #1; n++; end
        check("hold_reached", valid_a, 1);
        for (int i = 0; i < 20; i++) begin
            check("hold_valid", valid_a, 1);
            check("hold_busy",  busy_a,  0);
            check("hold_class", class_a, 5);
            check("hold_count", count_b, 3);
            start = (i == 5);
            @(posedge clk); #1;
        end
        start = 1'b0;
        res_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs_start_valid_a", valid_a, 0);
        check("hs_start_busy_a",  busy_a,  1);
        check("hs_start_valid_b", valid_b, 0);
        check("hs_count_seen",    hs_a,    6);

        // Reset mid-COUNT aborts the window; no result may follow.
        run_count(8, 100);
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("midrst");
        rst = 1'b0;
        run_count(8, 750);
        check("no_result_after_rst", hs_a, 6);
        check("queue_a_drained", q_a.size(), 0);
        check("queue_b_drained", q_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_class_decoder.md
Name: spike_class_decoder

Overview:
- Output-side decoder for the spiking classifier. It consumes the 10-bit `spike` vector from `system_top`, counts spikes per output neuron over one pattern-presentation window, and reports the winning class.
- It is the read-back end of the stimulus path: the bench drives a model number (`in_cnt` 1..10) into the network; this block turns spikes back into a class number on the same 1..10 scale.
- Result is returned through a valid/ready handshake.

Parameters:
- N_OUT, 10, number of output neurons / classes
- WINDOW, 672, presentation window length in clk cycles (2 × 336)
- CNT_W, 10, per-neuron spike counter width (saturating)
- ID_W, 4, class id width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- spike  in  N_OUT  spike vector from network, bit i = neuron i fired this cycle
- learn  in  1  network is in a learning presentation
- start  in  1  single-cycle pulse: begin a new presentation window
- busy  out  1  high in COUNT and SCAN states
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_class  out  ID_W  winning class, 1..N_OUT; 0 = no spikes in window
- res_count  out  CNT_W  spike count of winner
- res_tie  out  1  another neuron equalled the winning count (count > 0)
- res_learn  out  1  `learn` was high on any counted cycle of the window

Behaviour:
- Reset (synchronous, active-high): state IDLE; all counters 0; `busy`, `res_valid`, `res_tie`, `res_learn` = 0; `res_class`, `res_count` = 0. Reset asserted mid-window or mid-scan aborts the operation, and no result is produced.
- States: IDLE, COUNT, SCAN, HOLD.
- IDLE:
  - `start` = 1 → COUNT.
  - Clear all N_OUT counters, window counter `wcnt` = 0, and the learn latch.
- COUNT, each cycle:
  - Counter[i] += `spike[i]`, saturating at 2^CNT_W−1.
  - Learn latch |= `learn`.
  - `wcnt` increments.
  - Exactly WINDOW cycles are counted: the first is the cycle after `start`. When `wcnt` = WINDOW−1 → SCAN.
  - `start` during COUNT restarts the window: counters, `wcnt` and learn latch are cleared next cycle, and the state stays COUNT. The spikes of the `start` cycle are not counted.
- SCAN: sequential argmax, one neuron per cycle, index j = 0..N_OUT−1, so it takes N_OUT cycles.
  - Running best starts at count 0, class 0, tie 0.
  - If counter[j] > best → best = counter[j], class = j+1, tie = 0.
  - Else if counter[j] == best and best > 0 → tie = 1.
  - The lowest index wins on ties.
  - After j = N_OUT−1 → HOLD.
  - `start` is ignored in SCAN.
- HOLD:
  - `res_valid` = 1 and all `res_*` outputs are stable until the handshake.
  - `res_valid` & `res_ready` → IDLE, `res_valid` drops the next cycle.
  - If `start` = 1 in the same cycle as the handshake → COUNT directly, with counters cleared.
  - `start` in HOLD without `res_ready` is ignored and not queued.
- Latency: `start` at cycle 0 → `res_valid` first high at cycle WINDOW + N_OUT + 1 (683 with defaults).
- Outputs `res_*` are registered and update only on entry to HOLD. They hold their last values in IDLE/COUNT/SCAN, but are meaningful only while `res_valid` = 1.
- `busy` = 1 exactly in COUNT and SCAN.
- Width rules:
  - `wcnt` is wide enough for WINDOW−1 (⌈log2 WINDOW⌉).
  - The class index is ID_W bits, and N_OUT ≤ 2^ID_W − 1 is checked at elaboration.

Decomposition:
- Shared package `snn_pkg`:
  - State enum (IDLE/COUNT/SCAN/HOLD)
  - CLASS_NONE = 0
  - N_OUT, WINDOW, CNT_W, ID_W defaults
- One natural sub-module: `spike_count_bank`, N_OUT saturating counters with clear, enable and an indexed read port. The FSM, window counter and argmax stay in the top.

Test Plan:
- Neuron 3 only, spikes every 4th cycle for 672 cycles, `res_ready` held 1 → `res_valid` at cycle 683; `res_class` = 4, `res_count` = 168, `res_tie` = 0, `res_learn` = 0.
- Neurons 2 and 7 each spike 50 times, all others 0 → `res_class` = 3, `res_count` = 50, `res_tie` = 1.
- No spikes in the window → `res_class` = 0, `res_count` = 0, `res_tie` = 0, `res_valid` still asserted at cycle 683.
- Neuron 0 spikes every cycle with CNT_W = 8 → `res_count` saturates at 255, `res_class` = 1. `learn` pulsed once mid-window → `res_learn` = 1.
- `start` re-pulsed at cycle 300 with spikes only before it → counts cleared; result at cycle 300 + 683 reflects only later spikes. `start` during SCAN has no effect.
- `res_ready` held 0 for 20 cycles → outputs stable, `start` ignored. Then `res_ready` and `start` high together → `res_valid` falls next cycle and `busy` rises. Sync `rst` mid-COUNT → all outputs 0 and no result.
